// File: rtl/jt1942_objdma.sv
// rtl/jt1942_objdma.sv - object-RAM DMA engine copying CPU object RAM into the sprite shadow RAM
//
// Purpose:
//   On each falling edge of LVBL (start of vertical blank) the engine requests
//   the CPU bus, then streams `len` words from the CPU-side object RAM read
//   port into the shadow object RAM, one word per cen tick. Losing the bus
//   mid-copy parks the engine in REQ; the word that was in flight is re-read
//   after the grant returns, so nothing is skipped or duplicated.
//
// Optional feature:
//   JT1942_OBJDMA_ABORT_EN - when defined, LVBL rising while busy aborts the
//   copy and pulses the extra `abort` output. When undefined the copy always
//   completes and the `abort` port does not exist.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   cen              clock enable; state moves only on cen ticks
//   LVBL             active-low vertical blank
//   bus_ack/bus_req  CPU bus grant / request
//   src_addr, src_q  source RAM address and its registered read data
//   dst_addr, dst_data, dst_we  shadow RAM write port (writes on cen && dst_we)
//   busy, done       copy in progress / one-tick completion pulse
//   abort            one-tick abort pulse (JT1942_OBJDMA_ABORT_EN only)

module jt1942_objdma #(
  parameter int dw  = 8,
  parameter int aw  = 7,
  parameter int len = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          LVBL,
  input  logic          bus_ack,
  output logic          bus_req,
  output logic [aw-1:0] src_addr,
  input  logic [dw-1:0] src_q,
  output logic [aw-1:0] dst_addr,
  output logic [dw-1:0] dst_data,
  output logic          dst_we,
  output logic          busy,
`ifdef JT1942_OBJDMA_ABORT_EN
  output logic          abort,
`endif
  output logic          done
);

  localparam int cw = aw + 1;
  localparam logic [cw-1:0] LEN_C = cw'(len);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    PRIME = 2'd2,
    COPY  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [cw-1:0] rd_cnt_q, rd_cnt_d;
  logic          bus_req_q, bus_req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [aw-1:0] src_addr_q, src_addr_d;
  logic [aw-1:0] dst_addr_q, dst_addr_d;
  logic          lvbl_q, lvbl_d;
  logic [cw-1:0] rd_inc;
  logic [cw-1:0] rd_dec;
  logic          lvbl_fall;
  logic          abort_now;

  assign rd_inc    = rd_cnt_q + 1'b1;
  assign rd_dec    = rd_cnt_q - 1'b1;
  assign lvbl_fall = lvbl_q & ~LVBL;

`ifdef JT1942_OBJDMA_ABORT_EN
  logic abort_q, abort_d;
  // Abort is evaluated combinationally so the write that would land on the
  // aborting tick is suppressed and the shadow RAM keeps only earlier words.
  assign abort_now = busy_q & ~lvbl_q & LVBL;
  assign abort     = abort_q;
`else
  assign abort_now = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    bus_req_d  = bus_req_q;
    busy_d     = busy_q;
    done_d     = done_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    lvbl_d     = lvbl_q;
`ifdef JT1942_OBJDMA_ABORT_EN
    abort_d    = abort_q;
`endif
    if (cen) begin
      // LVBL history is tracked in every state so a fall seen while busy
      // is consumed and cannot fire once the copy finishes.
      lvbl_d = LVBL;
      done_d = 1'b0;
`ifdef JT1942_OBJDMA_ABORT_EN
      abort_d = 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (lvbl_fall) begin
            state_d   = REQ;
            rd_cnt_d  = '0;
            bus_req_d = 1'b1;
            busy_d    = 1'b1;
          end
        end
        REQ: begin
          if (bus_ack) begin
            state_d    = PRIME;
            src_addr_d = rd_cnt_q[aw-1:0];
          end
        end
        PRIME: begin
          if (bus_ack) begin
            state_d    = COPY;
            rd_cnt_d   = rd_inc;
            src_addr_d = rd_inc[aw-1:0];
            dst_addr_d = rd_cnt_q[aw-1:0];
          end else begin
            state_d = REQ;
          end
        end
        COPY: begin
          if (bus_ack) begin
            rd_cnt_d   = rd_inc;
            src_addr_d = rd_inc[aw-1:0];
            dst_addr_d = rd_cnt_q[aw-1:0];
            if (rd_cnt_q == LEN_C) begin
              state_d   = IDLE;
              done_d    = 1'b1;
              bus_req_d = 1'b0;
              busy_d    = 1'b0;
            end
          end else begin
            // The word read for this tick was never written; step back so
            // PRIME re-reads it once the bus returns.
            rd_cnt_d = rd_dec;
            state_d  = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef JT1942_OBJDMA_ABORT_EN
      if (abort_now) begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        abort_d   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      bus_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      lvbl_q     <= 1'b1;
`ifdef JT1942_OBJDMA_ABORT_EN
      abort_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      bus_req_q  <= bus_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      lvbl_q     <= lvbl_d;
`ifdef JT1942_OBJDMA_ABORT_EN
      abort_q    <= abort_d;
`endif
    end
  end

  assign bus_req  = bus_req_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_we   = (state_q == COPY) && bus_ack && !abort_now;
  // The source RAM read port is already registered, so its output is the
  // pipeline stage for write data; it is gated to zero outside COPY so the
  // port idles (and resets) at zero.
  assign dst_data = (state_q == COPY) ? src_q : '0;

endmodule

// File: doc/jt1942_objdma.md
# jt1942_objdma

Object-RAM DMA engine for the 1942 video path, placed directly downstream of the CPU-side object `jtgng_ram`. On each vertical-blank start it requests the CPU bus and copies `len` words from that RAM's read port into the shadow object RAM read by the sprite renderer. Each word moves in one `cen` tick, and the engine pauses cleanly if the bus is taken back.

## Interface
Parameters:
- `dw`, 8: data width
- `aw`, 7: address width of source and destination RAMs
- `len`, 128: words copied per frame; 1 ≤ len ≤ 2**aw

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  asynchronous active-low reset
- `cen`  in  1  clock enable; all state advances only on `clk` edges with `cen`=1
- `LVBL`  in  1  active-low vertical blank
- `bus_ack`  in  1  CPU bus granted; synchronous to `clk`
- `bus_req`  out  1  CPU bus request
- `src_addr`  out  aw  source RAM address; read data appears on `src_q` one `cen` tick later
- `src_q`  in  dw  source RAM registered read data
- `dst_addr`  out  aw  shadow RAM address
- `dst_data`  out  dw  shadow RAM write data
- `dst_we`  out  1  shadow RAM write strobe; the RAM writes when `cen` && `dst_we`
- `busy`  out  1  high from trigger until completion
- `done`  out  1  one-`cen`-tick pulse on the completing tick

## Operation
- States are IDLE, REQ, PRIME and COPY. `rd_cnt` is aw+1 bits wide.
- **IDLE → REQ:** taken when `LVBL` is sampled 1 on the previous `cen` tick and 0 on this one (falling edge). `rd_cnt` is set to 0, and `bus_req` and `busy` go to 1.
- **REQ → PRIME:** taken on a `cen` tick with `bus_ack`=1.
- **PRIME:**
  - `src_addr`=`rd_cnt`; no write.
  - With `bus_ack`=1: `rd_cnt`++ and go to COPY.
  - With `bus_ack`=0: return to REQ.
- **COPY, `bus_ack`=1:**
  - `dst_we`=1, `dst_addr`=`rd_cnt`-1, `dst_data`=`src_q`, `src_addr`=`rd_cnt`[aw-1:0] (wraps).
  - Each tick, `rd_cnt`++.
  - When `rd_cnt`==`len` on that tick: go to IDLE, pulse `done`=1, and clear `bus_req` and `busy`.
- **COPY, `bus_ack`=0:** `dst_we`=0, `rd_cnt`--, return to REQ. The pending word is re-read in PRIME after the grant returns.
- `dst_we` is combinational: (state==COPY) && `bus_ack`. All other outputs are registered.
- A falling edge of `LVBL` while `busy` is ignored; there is no restart and nothing is queued.
- `LVBL` edge detection continues in every state, so a fall during `busy` does not re-fire after completion.
- Reset (asynchronous, any state): state IDLE, `rd_cnt`=0, `bus_req`=0, `busy`=0, `done`=0, `src_addr`=0, `dst_addr`=0, `dst_data`=0. The `LVBL` history register resets to 1.

## Timing
- Trigger to `bus_req`: 1 `cen` tick after the tick that samples `LVBL`=0.
- Grant to first write: the first write occurs 2 `cen` ticks after the tick that sees `bus_ack`=1 (1 tick in PRIME, then the first COPY tick).
- Uninterrupted copy: 1 PRIME tick + `len` COPY ticks. `done` and the `bus_req` drop occur on the tick after the last write.
- Each bus loss costs 1 extra PRIME tick after re-grant, plus the ticks spent waiting in REQ.
- Throughput: one word per `cen` tick in COPY.
- With `cen`=0, the state and all registered outputs hold. `dst_we` may be 1, but no write occurs.

## Configuration
- Macro `JT1942_OBJDMA_ABORT_EN`.
- **Defined:**
  - `LVBL` rising while `busy` aborts: go to IDLE on that tick, and clear `bus_req` and `busy`.
  - `done` stays 0, and the output `abort` pulses for 1 `cen` tick.
  - The shadow RAM keeps the partially copied contents.
- **Undefined:**
  - `LVBL` rising has no effect; the copy always completes.
  - The `abort` port is absent.

## Test plan
- **Basic copy:** `len`=128, source RAM holds addr^8'h5A; pulse `LVBL` low; `bus_ack` follows `bus_req` after 3 ticks → shadow[i]==i^8'h5A for all i. There are exactly 128 `dst_we` ticks, one `done` pulse, and `bus_req` falls 1 tick after the last write.
- **Bus loss:** drop `bus_ack` for 5 ticks after the 40th write → `dst_we`=0 while low. On re-grant, 1 PRIME tick re-reads addr 40 and writing resumes at dst_addr 40. No duplicates or skips; the shadow RAM is fully correct.
- **Retrigger:** second `LVBL` fall while `busy` → no restart; exactly one `done` is produced, and no second copy happens until the next fall after `busy`=0.
- **Reset mid-copy:** assert `rst_n`=0 at write 60 → `bus_req`, `busy` and `dst_we` go to 0 immediately, asynchronously. A new `LVBL` fall then performs a full 128-word copy.
- **`cen` gating:** `cen` toggling 1-of-4 → identical final shadow contents and tick counts measured in `cen` ticks.
- **Abort (`JT1942_OBJDMA_ABORT_EN`):** `LVBL` rises at write 20 → `abort` pulses, `done` never asserts, and `bus_req` drops that tick. Shadow[0..19] are updated and shadow[20..] are unchanged.
